// File: rtl/ext_mdu_pkg.sv
// Shared definitions for the external RV32M multiply/divide unit.
// Package mdu_pkg: operand width, funct3 codes, FSM state type, special-case constants
// and a small sign helper. XLEN can be overridden with the `XLEN macro (default 32).

`ifndef XLEN
`define XLEN 32
`endif

package mdu_pkg;

  localparam int unsigned XLEN = `XLEN;
  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] CNT_LAST = CntW'(XLEN - 1);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_t;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/ext_mdu_if.sv
// Request/response bundle between the execute stage and ext_mdu.
// master (execute stage): drives i_en, i_rs1, i_rs2, i_f3; receives o_res, o_ack, o_busy.
// slave  (ext_mdu):       the reverse.
// Signal names keep the responder-side i_/o_ prefixes of the handshake.

interface ext_mdu_if;
  import mdu_pkg::*;

  logic            i_en;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic [2:0]      i_f3;
  logic [XLEN-1:0] o_res;
  logic            o_ack;
  logic            o_busy;

  modport master (
    output i_en, i_rs1, i_rs2, i_f3,
    input  o_res, o_ack, o_busy
  );

  modport slave (
    input  i_en, i_rs1, i_rs2, i_f3,
    output o_res, o_ack, o_busy
  );

endinterface

// File: rtl/ext_mdu_divider.sv
// mdu_divider: iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   i_clk, i_rst (sync, active-low)
//   i_start     load dividend/divisor and begin XLEN iterations
//   i_dividend, i_divisor  unsigned operands, sampled on i_start
//   o_done      high during the final iteration
//   o_quot, o_rem  results after the current iteration; final while o_done is high

module mdu_divider
  import mdu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;

  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quot_step;

  // quot_q doubles as the dividend shift register; quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quot_q[XLEN-1]};
    diff  = trial - {1'b0, dvsr_q};
    if (diff[XLEN]) begin
      rem_step  = trial[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b0};
    end else begin
      rem_step  = diff[XLEN-1:0];
      quot_step = {quot_q[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (i_start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quot_d = i_dividend;
      rem_d  = '0;
      dvsr_d = i_divisor;
    end else if (busy_q) begin
      quot_d = quot_step;
      rem_d  = rem_step;
      cnt_d  = cnt_q + CntW'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign o_done = busy_q && (cnt_q == CNT_LAST);
  assign o_quot = quot_step;
  assign o_rem  = rem_step;

endmodule

// File: rtl/ext_mdu.sv
// ext_mdu: external RV32M responder (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Ports:
//   i_clk   clock
//   i_rst   synchronous, active-low reset
//   bus     ext_mdu_if.slave: i_en request pulse with i_rs1/i_rs2/i_f3; o_res result,
//           o_ack one-cycle completion pulse, o_busy while an operation is in flight.
// Build option: define EXT_MDU_SINGLE_CYCLE_MUL_EN for a combinational multiplier
// (multiplies complete with latency 1); otherwise a radix-2 shift-add loop is used.

module ext_mdu
  import mdu_pkg::*;
(
  input logic      i_clk,
  input logic      i_rst,
  ext_mdu_if.slave bus
);

  mdu_state_t      state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            neg_q, neg_d;    // product / quotient sign
  logic            rneg_q, rneg_d;  // remainder sign
  logic [XLEN-1:0] res_q, res_d;
  logic            ack_q, ack_d;
  logic            busy;

  logic            accept;
  logic            rs1_signed, rs2_signed;
  logic            sgn1, sgn2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf;
  logic            mul_last;

  logic            div_start, div_done;
  logic [XLEN-1:0] div_quot, div_rem, div_res;

  // While the ack from the previous request is showing, the next request is held off.
  assign accept = (state_q == StIdle) && bus.i_en && !ack_q;

  // Operand decode happens on the live inputs; only what is needed later is latched.
  always_comb begin
    rs1_signed = (bus.i_f3 == F3_MULH) || (bus.i_f3 == F3_MULHSU) ||
                 (bus.i_f3 == F3_DIV)  || (bus.i_f3 == F3_REM);
    rs2_signed = (bus.i_f3 == F3_MULH) || (bus.i_f3 == F3_DIV) || (bus.i_f3 == F3_REM);
    sgn1       = rs1_signed && bus.i_rs1[XLEN-1];
    sgn2       = rs2_signed && bus.i_rs2[XLEN-1];
    mag1       = negate_if(bus.i_rs1, sgn1);
    mag2       = negate_if(bus.i_rs2, sgn2);
    div_zero   = bus.i_f3[2] && (bus.i_rs2 == '0);
    div_ovf    = bus.i_f3[2] && !bus.i_f3[0] && (bus.i_rs1 == SIGNED_MIN) && (bus.i_rs2 == '1);
  end

`ifdef EXT_MDU_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN-1:0] prod_raw, prod_fast;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    prod_raw  = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    prod_fast = (sgn1 ^ sgn2) ? -prod_raw : prod_raw;
    fast_res  = (bus.i_f3 == F3_MUL) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
  end

  assign mul_last = 1'b0;
`else
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   mul_res;

  // acc = {partial product high half, remaining multiplier bits}; shift right each cycle.
  always_comb begin
    psum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    acc_step = {psum, acc_q[XLEN-1:1]};
    prod     = neg_q ? -acc_step : acc_step;
    mul_res  = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d = {{XLEN{1'b0}}, mag1};
      b_d   = mag2;
      cnt_d = '0;
    end else if (state_q == StMul) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign mul_last = (state_q == StMul) && (cnt_q == CNT_LAST);
`endif

  assign div_start = accept && bus.i_f3[2] && !div_zero && !div_ovf;

  mdu_divider u_divider (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (div_start),
    .i_dividend (mag1),
    .i_divisor  (mag2),
    .o_done     (div_done),
    .o_quot     (div_quot),
    .o_rem      (div_rem)
  );

  assign div_res = f3_q[1] ? negate_if(div_rem, rneg_q) : negate_if(div_quot, neg_q);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (div_zero || div_ovf) begin
            state_d = StDone;
          end else if (bus.i_f3[2]) begin
            state_d = StDiv;
          end else begin
`ifdef EXT_MDU_SINGLE_CYCLE_MUL_EN
            state_d = StDone;
`else
            state_d = StMul;
`endif
          end
        end
      end
      StMul:   if (mul_last) state_d = StDone;
      StDiv:   if (div_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; ack is registered so it trails the DONE state by one cycle.
  always_comb begin
    busy  = (state_q != StIdle);
    ack_d = (state_q == StDone);
  end

  // Request latch and result register.
  always_comb begin
    f3_d   = f3_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    res_d  = res_q;
    if (accept) begin
      f3_d   = bus.i_f3;
      neg_d  = sgn1 ^ sgn2;
      rneg_d = sgn1;
      if (div_zero) begin
        res_d = bus.i_f3[1] ? bus.i_rs1 : DIV_ZERO_Q;
      end else if (div_ovf) begin
        res_d = bus.i_f3[1] ? '0 : SIGNED_MIN;
`ifdef EXT_MDU_SINGLE_CYCLE_MUL_EN
      end else if (!bus.i_f3[2]) begin
        res_d = fast_res;
`endif
      end
    end else if (mul_last) begin
`ifndef EXT_MDU_SINGLE_CYCLE_MUL_EN
      res_d = mul_res;
`endif
    end else if ((state_q == StDiv) && div_done) begin
      res_d = div_res;
    end
  end

  // State register and datapath flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= StIdle;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.o_res  = res_q;
  assign bus.o_ack  = ack_q;
  assign bus.o_busy = busy;

endmodule

// File: tb/tb_ext_mdu.sv
// Self-checking bench for ext_mdu: directed cases plus randomized operations checked
// against an arithmetic reference model.

module tb_ext_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_mdu_if bus ();

  ext_mdu u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

`ifdef EXT_MDU_SINGLE_CYCLE_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  // RV32M semantics computed with plain 64-bit / integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ai, bi, qi;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ai = a;
    bi = b;
    r  = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin qi = ai / bi; r = qi; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin qi = ai % bi; r = qi; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!f3[2]) return MulLat;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs afterwards, and check latency/result/ack width.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
    int          lat;
    logic [31:0] exp;
    exp = ref_mdu(f3, a, b);
    @(negedge clk);
    bus.i_en  = 1'b1;
    bus.i_f3  = f3;
    bus.i_rs1 = a;
    bus.i_rs2 = b;
    @(posedge clk); #1;
    bus.i_en  = 1'b0;
    bus.i_rs1 = $urandom;
    bus.i_rs2 = $urandom;
    bus.i_f3  = 3'($urandom);
    check({tag, "/busy"}, {31'b0, bus.o_busy}, 32'd1);
    lat = 0;
    while (bus.o_ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, lat, exp_lat(f3, a, b));
    check({tag, "/res"}, bus.o_res, exp);
    @(posedge clk); #1;
    check({tag, "/ackw"}, {31'b0, bus.o_ack}, 32'd0);
  endtask

  initial begin
    int          acks;
    int          ack_edge;
    logic [31:0] seen_res;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    rst       = 1'b0;
    bus.i_en  = 1'b0;
    bus.i_rs1 = '0;
    bus.i_rs2 = '0;
    bus.i_f3  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ack", {31'b0, bus.o_ack}, 32'd0);
    check("rst/res", bus.o_res, 32'd0);
    check("rst/busy", {31'b0, bus.o_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul",    F3_MUL,    32'hFFFF_FFFF, 32'd7);
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", F3_MULHSU, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu",  F3_MULHU,  32'h8000_0000, 32'h8000_0000);
    run_op("div",    F3_DIV,    32'hFFFF_FFF9, 32'd2);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9, 32'd2);
    run_op("divu",   F3_DIVU,   32'd100,       32'd7);
    run_op("remu",   F3_REMU,   32'd100,       32'd7);
    run_op("divu0",  F3_DIVU,   32'd5,         32'd0);
    run_op("rem0",   F3_REM,    32'd5,         32'd0);
    run_op("divovf", F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", F3_REM,    32'h8000_0000, 32'hFFFF_FFFF);

    // New operands and a second i_en at cycle 10 of a DIV must be ignored.
    @(negedge clk);
    bus.i_en  = 1'b1;
    bus.i_f3  = F3_DIV;
    bus.i_rs1 = 32'hDEAD_BEEF;
    bus.i_rs2 = 32'h0000_1234;
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_en  = 1'b1;
    bus.i_rs1 = 32'd1000;
    bus.i_rs2 = 32'd3;
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    acks     = 0;
    ack_edge = -1;
    seen_res = '0;
    for (int e = 11; e < 60; e++) begin
      @(posedge clk); #1;
      if (bus.o_ack === 1'b1) begin
        acks++;
        if (ack_edge < 0) begin
          ack_edge = e;
          seen_res = bus.o_res;
        end
      end
    end
    check("robust/acks", acks, 32'd1);
    check("robust/lat", ack_edge, 32'd33);
    check("robust/res", seen_res, ref_mdu(F3_DIV, 32'hDEAD_BEEF, 32'h0000_1234));

    // Reset at cycle 15 of a MUL drops the request.
    @(negedge clk);
    bus.i_en  = 1'b1;
    bus.i_f3  = F3_MUL;
    bus.i_rs1 = 32'h1234_5678;
    bus.i_rs2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.i_en = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst/ack", {31'b0, bus.o_ack}, 32'd0);
    check("midrst/res", bus.o_res, 32'd0);
    check("midrst/busy", {31'b0, bus.o_busy}, 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    acks = 0;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk); #1;
      if (bus.o_ack === 1'b1) acks++;
    end
    check("midrst/noack", acks, 32'd0);
    run_op("postrst", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Randomized operations, with divide-by-zero and overflow forced now and then.
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op("rand", rf3, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ext_mdu.md
Name: ext_mdu

Overview:
- Responder side of the external RV32M handshake. The execute stage issues a one-cycle request pulse with operands rs1/rs2 and funct3.
- ext_mdu computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- It returns the result with a one-cycle ack pulse. It sits outside the core, next to the datapath, when the M extension is built external.

Parameters:
- XLEN, 32 (`XLEN), operand/result width; the iteration count equals XLEN.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-low
- i_en  input  1  request pulse; operands are valid in the same cycle
- i_rs1  input  XLEN  operand A (dividend / multiplicand)
- i_rs2  input  XLEN  operand B (divisor / multiplier)
- i_f3  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- o_res  output  XLEN  result; valid while o_ack=1, held until the next accepted request
- o_ack  output  1  completion pulse, exactly one cycle per accepted request
- o_busy  output  1  high in MUL, DIV and DONE states

Behaviour:
- Reset (i_rst=0 at a posedge) forces state IDLE and clears o_ack, o_res and all internal registers. This includes reset mid-operation; the in-flight request is dropped and no ack is issued.
- FSM states: IDLE, MUL, DIV, DONE. o_ack = (state==DONE), registered, with no combinational path from i_en.
- IDLE: i_en=1 is sampled at a posedge, the request is accepted, and rs1, rs2 and f3 are latched. Later changes on the inputs are ignored.
- IDLE, next state:
  - DIV with rs2==0, or signed DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: go to DONE (special case).
  - f3[2]=1 otherwise: go to DIV.
  - f3[2]=0: go to MUL.
- i_en outside IDLE is ignored and is not queued. This includes i_en during DONE. DONE always returns to IDLE.
- Signedness:
  - rs1 is signed for MULH, MULHSU, DIV and REM.
  - rs2 is signed for MULH, DIV and REM.
  - Signed operands are converted to magnitude at accept time, and the result sign is recorded.
- MUL state: radix-2 shift-add over the magnitudes, one bit per cycle, XLEN cycles, with a 2*XLEN-bit accumulator.
  - At exit the 64-bit product is negated if the signs differ.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- DIV state: restoring division, XLEN cycles, producing a quotient and a remainder.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow: quotient = 0x80000000, remainder = 0.
- Iteration counter runs 0..XLEN-1. The MUL/DIV state is left when the counter reaches XLEN-1, and the result is written into o_res on that transition.
- Latency from the i_en sample edge to o_ack high:
  - Special cases: 1 cycle.
  - MUL and DIV: XLEN+1 cycles (33).
- Back-to-back: the next request is accepted at the earliest in the cycle after o_ack.

Optional Feature:
- Macro EXT_MDU_SINGLE_CYCLE_MUL_EN.
- Defined: multiply uses a combinational XLEN x XLEN signed/unsigned multiplier. IDLE goes straight to DONE for f3[2]=0 (latency 1), and the MUL state and shift-add datapath are not synthesized.
- Undefined: the iterative MUL path above is used (latency 33). Results are bit-identical in both builds.

Decomposition:
- Shared package mdu_pkg holds:
  - the f3 localparams (F3_MUL .. F3_REMU);
  - the state enum typedef mdu_state_t;
  - the constants DIV_ZERO_Q (all ones) and SIGNED_MIN (0x80000000).
- One sub-module, mdu_divider: an iterative restoring divider with start, done, unsigned magnitude inputs, and quotient/remainder outputs. Sign fixup and special cases stay in ext_mdu.

Test Plan:
- MUL rs1=0xFFFFFFFF (-1), rs2=7 -> o_res=0xFFFFFFF9, o_ack exactly at cycle 33 (cycle 1 with the macro), one cycle wide.
- MULH rs1=0x80000000, rs2=0x80000000 -> 0x40000000. MULHSU same operands -> 0xC0000000. MULHU -> 0x40000000.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD (-3). REM same -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU -> 2. Each acks at cycle 33.
- Special cases, each acking at cycle 1:
  - DIVU rs1=5, rs2=0 -> 0xFFFFFFFF.
  - REM rs1=5, rs2=0 -> 5.
  - DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Operand/request robustness:
  - Change rs1/rs2 and pulse i_en again at cycle 10 of a DIV -> the result uses the originally latched operands and only one ack is produced.
- Reset and back-to-back:
  - Drive i_rst=0 at cycle 15 of a MUL -> o_ack=0, o_res=0, o_busy=0 next cycle, and no ack ever appears for that request.
  - A new request issued after the ack completes normally.
